// File: rtl/gcd_multilane_unit_pkg.sv
// Shared types and helpers for the multi-lane GCD accelerator.
package gcd_multilane_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } lane_state_t;

    // Pointer width for a lane count, never narrower than one bit.
    function automatic int ptr_width(input int nlanes);
        return (nlanes > 1) ? $clog2(nlanes) : 1;
    endfunction

endpackage

// File: rtl/gcd_multilane_unit_lane.sv
// One subtractive-Euclid GCD lane: IDLE -> CALC (one step per cycle) -> DONE.
module gcd_multilane_unit_lane
    import gcd_multilane_unit_pkg::*;
#(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output lane_state_t state,
    output logic [W-1:0] result,
    input  logic        ack
);

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        op_a  <= a;
                        op_b  <= b;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (op_a < op_b) begin
                        op_a <= op_b;
                        op_b <= op_a;
                    end else if (op_b != '0) begin
                        op_a <= op_a - op_b;
                    end else begin
                        result <= op_a;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gcd_multilane_unit.sv
// NLANES GCD lanes fed round-robin; responses are collected in the same order to keep them in request order.
module gcd_multilane_unit
    import gcd_multilane_unit_pkg::*;
#(
    parameter int W      = 16,
    parameter int NLANES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req_val,
    output logic           req_rdy,
    input  logic [2*W-1:0] req_msg,
    output logic           resp_val,
    input  logic           resp_rdy,
    output logic [W-1:0]   resp_msg,
    output logic           busy
);

    localparam int PTR_W = ptr_width(NLANES);

    logic [PTR_W-1:0] disp_ptr;
    logic [PTR_W-1:0] coll_ptr;
    lane_state_t      lane_state  [NLANES];
    logic [W-1:0]     lane_result [NLANES];
    logic [NLANES-1:0] lane_load;
    logic [NLANES-1:0] lane_ack;
    logic [NLANES-1:0] lane_busy;
    logic             req_fire;
    logic             resp_fire;

    // Readiness looks only at registered lane state, so it never depends on resp_rdy.
    assign req_rdy   = reset_n && (lane_state[disp_ptr] == IDLE);
    assign resp_val  = (lane_state[coll_ptr] == DONE);
    assign resp_msg  = lane_result[coll_ptr];
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;
    assign busy      = |lane_busy;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign lane_load[i] = req_fire && (disp_ptr == PTR_W'(i));
        assign lane_ack[i]  = resp_fire && (coll_ptr == PTR_W'(i));
        assign lane_busy[i] = (lane_state[i] != IDLE);

        gcd_multilane_unit_lane #(
            .W(W)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (lane_load[i]),
            .a      (req_msg[2*W-1:W]),
            .b      (req_msg[W-1:0]),
            .state  (lane_state[i]),
            .result (lane_result[i]),
            .ack    (lane_ack[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_ptr <= '0;
            coll_ptr <= '0;
        end else begin
            if (req_fire) begin
                disp_ptr <= (disp_ptr == PTR_W'(NLANES - 1)) ? '0 : disp_ptr + 1'b1;
            end
            if (resp_fire) begin
                coll_ptr <= (coll_ptr == PTR_W'(NLANES - 1)) ? '0 : coll_ptr + 1'b1;
            end
        end
    end

endmodule
